// File: rtl/max7219_serial_tx.sv
// Serial shifter for a MAX7219-style display controller: one command word per handshake,
// shifted out MSB first on SCK and framed by an active-low LOAD.
module max7219_serial_tx #(
  parameter int CLK_DIV    = 4,
  parameter int WORD_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_serial_dout,
  output logic                  o_serial_load,
  output logic                  o_serial_clk
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(WORD_WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;

  state_t                state_reg, state_next;
  logic [DIV_W-1:0]      div_reg, div_next;
  logic [BIT_W-1:0]      bit_reg, bit_next;
  logic [WORD_WIDTH-1:0] shreg_reg, shreg_next;
  logic                  dout_reg, dout_next;
  logic                  load_reg, load_next;
  logic                  sck_reg, sck_next;
  logic                  busy_reg, busy_next;

  assign o_ready       = (state_reg == IDLE) & i_en;
  assign o_busy        = busy_reg;
  assign o_serial_dout = dout_reg;
  assign o_serial_load = load_reg;
  assign o_serial_clk  = sck_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      bit_reg   <= '0;
      shreg_reg <= '0;
      dout_reg  <= 1'b0;
      load_reg  <= 1'b1;
      sck_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      shreg_reg <= shreg_next;
      dout_reg  <= dout_next;
      load_reg  <= load_next;
      sck_reg   <= sck_next;
      busy_reg  <= busy_next;
    end
  end

  // Output registers are loaded with the values of the state being entered,
  // so every serial pin changes exactly on the transition edge.
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    shreg_next = shreg_reg;
    dout_next  = dout_reg;
    load_next  = load_reg;
    sck_next   = sck_reg;
    busy_next  = busy_reg;
    case (state_reg)
      IDLE: begin
        if (i_valid && o_ready) begin
          state_next = SHIFT;
          div_next   = '0;
          bit_next   = '0;
          shreg_next = i_data;
          dout_next  = i_data[WORD_WIDTH-1];
          load_next  = 1'b0;
          sck_next   = 1'b0;
          busy_next  = 1'b1;
        end
      end
      SHIFT: begin
        if (div_reg != DIV_LAST) begin
          div_next = div_reg + DIV_W'(1);
        end else begin
          div_next = '0;
          if (!sck_reg) begin
            sck_next = 1'b1;
          end else begin
            sck_next = 1'b0;
            if (bit_reg == BIT_LAST) begin
              state_next = LATCH;
            end else begin
              // Next bit is presented together with the SCK falling edge.
              bit_next   = bit_reg + BIT_W'(1);
              shreg_next = {shreg_reg[WORD_WIDTH-2:0], 1'b0};
              dout_next  = shreg_reg[WORD_WIDTH-2];
            end
          end
        end
      end
      LATCH: begin
        if (div_reg != DIV_LAST) begin
          div_next = div_reg + DIV_W'(1);
        end else begin
          div_next   = '0;
          state_next = GAP;
          load_next  = 1'b1;
          dout_next  = 1'b0;
        end
      end
      GAP: begin
        if (div_reg != DIV_LAST) begin
          div_next = div_reg + DIV_W'(1);
        end else begin
          div_next   = '0;
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        load_next  = 1'b1;
        sck_next   = 1'b0;
        dout_next  = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_max7219_serial_tx.sv
// Directed bench for max7219_serial_tx: three instances (CLK_DIV = 2, 1, 4) driven from a
// frame table plus hand-written reset, gating and back-to-back sequences.
module tb_max7219_serial_tx;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        en    [3];
  logic        valid [3];
  logic [15:0] data  [3];
  logic        ready [3];
  logic        busy  [3];
  logic        dout  [3];
  logic        load  [3];
  logic        sck   [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int CD = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
    max7219_serial_tx #(.CLK_DIV(CD), .WORD_WIDTH(16)) u_dut (
      .i_clk        (clk),
      .i_reset      (rst[gi]),
      .i_en         (en[gi]),
      .i_data       (data[gi]),
      .i_valid      (valid[gi]),
      .o_ready      (ready[gi]),
      .o_busy       (busy[gi]),
      .o_serial_dout(dout[gi]),
      .o_serial_load(load[gi]),
      .o_serial_clk (sck[gi])
    );
  end

  typedef struct {
    int          k;
    logic [15:0] word;
    bit          churn;
    int          en_drop;
    int          fall;
    int          rise;
    int          idle;
  } vec_t;

  vec_t vecs [5];

  int          r_fall, r_rise, r_idle, r_nrise, r_viol, r_acc;
  logic [15:0] r_bits;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Hands one word to instance k and observes the frame cycle by cycle until busy drops.
  task automatic run_frame(input int k, input logic [15:0] word, input bit churn,
                           input int en_drop, input bit hold);
    int c;
    logic pl, ps, pd;
    r_fall = -1; r_rise = -1; r_idle = -1; r_nrise = 0; r_viol = 0; r_bits = '0;
    en[k] = 1'b1;
    data[k] = word;
    valid[k] = 1'b1;
    @(posedge clk); #1;
    r_acc = cyc;
    if (!hold) valid[k] = 1'b0;
    pl = 1'b1; ps = 1'b0; pd = 1'b0;
    c = 1;
    while (c <= 200) begin
      if (pl && !load[k] && r_fall < 0) r_fall = c;
      if (!pl && load[k] && r_rise < 0) r_rise = c;
      if (!ps && sck[k]) begin
        r_bits = {r_bits[14:0], dout[k]};
        r_nrise++;
      end
      if (ps && sck[k] && (dout[k] != pd)) r_viol++;
      if (!busy[k]) begin
        r_idle = c;
        break;
      end
      pl = load[k]; ps = sck[k]; pd = dout[k];
      if (churn) data[k] = 16'($urandom);
      if (c == en_drop) en[k] = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    $display("frame dut=%0d word=%h bits=%h edges=%0d fall=%0d rise=%0d idle=%0d",
             k, word, r_bits, r_nrise, r_fall, r_rise, r_idle);
  endtask

  initial begin
    int acc1;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; en[i] = 1'b1; valid[i] = 1'b0; data[i] = '0;
    end

    vecs[0] = '{0, 16'h0A05, 1'b0, 0, 1, 67, 69};
    vecs[1] = '{1, 16'h8001, 1'b0, 0, 1, 34, 35};
    vecs[2] = '{2, 16'hA5C3, 1'b0, 0, 1, 133, 137};
    vecs[3] = '{0, 16'hC3A5, 1'b1, 0, 1, 67, 69};
    vecs[4] = '{0, 16'h5AA5, 1'b0, 10, 1, 67, 69};

    // Asynchronous reset asserted between clock edges.
    #2;
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    #1;
    chk("rst_load", int'(load[0]), 1);
    chk("rst_sck", int'(sck[0]), 0);
    chk("rst_dout", int'(dout[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_ready", int'(ready[0]), 1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(posedge clk); #1;

    // Disabled block ignores a valid word.
    en[0] = 1'b0; data[0] = 16'h1234; valid[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("gate_ready", int'(ready[0]), 0);
    chk("gate_busy", int'(busy[0]), 0);
    valid[0] = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].k, vecs[i].word, vecs[i].churn, vecs[i].en_drop, 1'b0);
      chk($sformatf("v%0d_fall", i), r_fall, vecs[i].fall);
      chk($sformatf("v%0d_rise", i), r_rise, vecs[i].rise);
      chk($sformatf("v%0d_idle", i), r_idle, vecs[i].idle);
      chk($sformatf("v%0d_bits", i), int'(r_bits), int'(vecs[i].word));
      chk($sformatf("v%0d_edges", i), r_nrise, 16);
      chk($sformatf("v%0d_dout_stable", i), r_viol, 0);
    end

    // After the enable-drop frame: nothing accepted until en returns.
    data[0] = 16'h7777; valid[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("endrop_ready", int'(ready[0]), 0);
    chk("endrop_busy", int'(busy[0]), 0);
    en[0] = 1'b1;
    #1;
    chk("enrestore_ready", int'(ready[0]), 1);
    valid[0] = 1'b0;
    @(posedge clk); #1;

    // Back-to-back with valid held high on CLK_DIV=1.
    run_frame(1, 16'hFFFF, 1'b0, 0, 1'b1);
    acc1 = r_acc;
    chk("b2b_bits1", int'(r_bits), 16'hFFFF);
    run_frame(1, 16'h0000, 1'b0, 0, 1'b0);
    chk("b2b_pitch", r_acc - acc1, 35);
    chk("b2b_bits2", int'(r_bits), 16'h0000);
    chk("b2b_edges2", r_nrise, 16);

    // Reset at cycle 20 of a CLK_DIV=4 frame.
    en[2] = 1'b1; data[2] = 16'hFFFF; valid[2] = 1'b1;
    @(posedge clk); #1;
    valid[2] = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("mid_load_before", int'(load[2]), 0);
    #2;
    rst[2] = 1'b1;
    #1;
    chk("mid_load", int'(load[2]), 1);
    chk("mid_sck", int'(sck[2]), 0);
    chk("mid_dout", int'(dout[2]), 0);
    chk("mid_busy", int'(busy[2]), 0);
    chk("mid_ready", int'(ready[2]), 1);
    @(posedge clk); #3;
    rst[2] = 1'b0;
    @(posedge clk); #1;
    run_frame(2, 16'h0C01, 1'b0, 0, 1'b0);
    chk("post_rst_bits", int'(r_bits), 16'h0C01);
    chk("post_rst_edges", r_nrise, 16);
    chk("post_rst_rise", r_rise, 133);
    chk("post_rst_idle", r_idle, 137);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
